// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^m) sequential reduction stage.
// Holds default field parameters, the controller state type and the
// fold-iteration count helper used by the reduction top.
package gf2m_pkg;

  localparam int unsigned M_DEFAULT        = 131;
  localparam int unsigned TAIL_DEG_DEFAULT = 8;
  // x^8 + x^3 + x^2 + 1 (sect131 pentanomial tail)
  localparam logic [130:0] TAIL_DEFAULT    = 131'h10D;

  typedef enum logic [1:0] {
    IDLE,
    FOLD,
    DONE
  } state_e;

  // Number of fold iterations needed to clear all degrees >= m of a
  // prod_w-coefficient product, folding `fold` coefficients per cycle.
  function automatic int unsigned ncyc(input int unsigned prod_w,
                                       input int unsigned m,
                                       input int unsigned fold);
    return (prod_w - m + fold - 1) / fold;
  endfunction

endpackage

// File: rtl/gf2m_reduce_seq_if.sv
// Handshake bundle between the carry-less multiplier, the reduction stage
// and the downstream consumer.
//   in_valid/in_ready/prod_in     : product input channel (2*M-1 coefficients)
//   out_valid/out_ready/res_out   : reduced M-bit result channel
//   busy                          : a reduction is in flight
// master = producer/consumer side, slave = reduction stage.
interface gf2m_reduce_seq_if
  import gf2m_pkg::*;
#(
  parameter int unsigned M = M_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [2*M-2:0]   prod_in;
  logic             out_valid;
  logic             out_ready;
  logic [M-1:0]     res_out;
  logic             busy;

  modport master (
    output in_valid, prod_in, out_ready,
    input  in_ready, out_valid, res_out, busy
  );

  modport slave (
    input  in_valid, prod_in, out_ready,
    output in_ready, out_valid, res_out, busy
  );

endinterface

// File: rtl/gf2m_fold_window.sv
// One reduction window of the sequential GF(2^m) reducer (combinational).
// For window index idx_i, every set coefficient at degree k in
// [lo, hi] (hi = 2M-2 - idx*FOLD, lo = max(M, hi-FOLD+1)) is cleared and
// TAIL << (k-M) is XORed back into the accumulator.
//   acc_i : accumulator before the fold (2*M-1 bits)
//   idx_i : window index (0 .. NCYC-1)
//   acc_o : accumulator after the fold
module gf2m_fold_window
  import gf2m_pkg::*;
#(
  parameter int unsigned M        = M_DEFAULT,
  parameter int unsigned FOLD     = 32,
  parameter int unsigned TAIL_DEG = TAIL_DEG_DEFAULT,
  parameter logic [M-1:0] TAIL    = M'(TAIL_DEFAULT),
  parameter int unsigned IDX_W    = 3
) (
  input  logic [2*M-2:0]   acc_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [2*M-2:0]   acc_o
);

  localparam int unsigned PROD_W = 2*M - 1;
  localparam logic [PROD_W-1:0] TAIL_W = PROD_W'(TAIL[TAIL_DEG:0]);

  int unsigned hi;
  int unsigned lo;

  // Reinserted terms land at most hi-(M-TAIL_DEG) < lo, so testing the
  // original acc_i bits is equivalent to a serial top-down fold.
  always_comb begin
    hi    = (PROD_W - 1) - 32'(idx_i) * FOLD;
    lo    = (hi >= M + FOLD - 1) ? (hi - FOLD + 1) : M;
    acc_o = acc_i;
    for (int unsigned k = M; k < PROD_W; k++) begin
      if ((k >= lo) && (k <= hi) && acc_i[k]) begin
        acc_o[k] = 1'b0;
        acc_o    = acc_o ^ (TAIL_W << (k - M));
      end
    end
  end

endmodule

// File: rtl/gf2m_reduce_seq.sv
// Sequential reduction of a carry-less product modulo f(x) = x^M + TAIL(x).
// Accepts a 2*M-1 coefficient product, folds FOLD coefficients per cycle
// for NCYC cycles (fixed latency), then presents the M-bit residue.
// Legal FOLD range: 1 .. M-TAIL_DEG-1.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (aborts any in-flight reduction)
//   bus  : slave side of gf2m_reduce_seq_if
//          in_valid/in_ready/prod_in, out_valid/out_ready/res_out, busy
module gf2m_reduce_seq
  import gf2m_pkg::*;
#(
  parameter int unsigned M        = M_DEFAULT,
  parameter int unsigned FOLD     = 32,
  parameter logic [M-1:0] TAIL    = M'(TAIL_DEFAULT),
  parameter int unsigned TAIL_DEG = TAIL_DEG_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  gf2m_reduce_seq_if.slave  bus
);

  localparam int unsigned PROD_W = 2*M - 1;
  localparam int unsigned NCYC   = ncyc(PROD_W, M, FOLD);
  localparam int unsigned CNT_W  = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCYC - 1);

  state_e             state_q;
  logic [PROD_W-1:0]  acc_q;
  logic [PROD_W-1:0]  acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [M-1:0]       res_q;

  gf2m_fold_window #(
    .M        (M),
    .FOLD     (FOLD),
    .TAIL_DEG (TAIL_DEG),
    .TAIL     (TAIL),
    .IDX_W    (CNT_W)
  ) u_fold (
    .acc_i (acc_q),
    .idx_i (cnt_q),
    .acc_o (acc_d)
  );

  // The FOLD parameter shadows the imported state literal, so the state is
  // referenced through the package scope.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      res_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            acc_q      <= bus.prod_in;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= gf2m_pkg::FOLD;
          end
        end
        gf2m_pkg::FOLD: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            res_q       <= acc_d[M-1:0];
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.res_out   = res_q;
  assign bus.busy      = busy_q;

  a_fully_reduced: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == DONE) |-> (acc_q[PROD_W-1:M] == '0)
  );

endmodule
